div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_if.sv | 13 +
 rtl/div_unit.sv | 150 +++++++++++++++
 tb/tb_div_unit.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - Request/response bundle between an issuing core and div_unit.
interface div_unit_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        busy;
   logic        done;
   logic [31:0] rd;

   modport master (output start, op, rs1, rs2, input busy, done, rd);
   modport slave  (input start, op, rs1, rs2, output busy, done, rd);
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - RV32M radix-2 restoring divider (DIV/DIVU/REM/REMU), fixed 34-cycle latency.
// Optional DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow skip CALC and finish in 2 cycles.
module div_unit (
   input  logic      clk,
   input  logic      rst,
   div_unit_if.slave bus
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] dvs_q, dvs_d;
   logic [31:0] rs1_q, rs1_d;
   logic [31:0] res_q, res_d;
   logic [31:0] rd_q, rd_d;
   logic        done_q, done_d;
   logic        is_rem_q, is_rem_d;
   logic        negq_q, negq_d;
   logic        negr_q, negr_d;
   logic        dz_q, dz_d;
   logic        ovf_q, ovf_d;

   logic        sgn_op, a_neg, b_neg, in_dz, in_ovf;
   logic [31:0] a_abs, b_abs, q_fix, r_fix;
   logic [32:0] shifted, trial;

   assign sgn_op  = ~bus.op[0];
   assign a_neg   = sgn_op & bus.rs1[31];
   assign b_neg   = sgn_op & bus.rs2[31];
   assign a_abs   = a_neg ? (~bus.rs1 + 32'd1) : bus.rs1;
   assign b_abs   = b_neg ? (~bus.rs2 + 32'd1) : bus.rs2;
   assign in_dz   = (bus.rs2 == 32'd0);
   assign in_ovf  = sgn_op & (bus.rs1 == 32'h8000_0000) & (bus.rs2 == 32'hFFFF_FFFF);

   // The remainder never exceeds the divisor, so 32 stored bits plus the shifted-in bit suffice.
   assign shifted = {rem_q, quo_q[31]};
   assign trial   = shifted - {1'b0, dvs_q};
   assign q_fix   = negq_q ? (~quo_q + 32'd1) : quo_q;
   assign r_fix   = negr_q ? (~rem_q + 32'd1) : rem_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      quo_d    = quo_q;
      rem_d    = rem_q;
      dvs_d    = dvs_q;
      rs1_d    = rs1_q;
      res_d    = res_q;
      rd_d     = rd_q;
      done_d   = 1'b0;
      is_rem_d = is_rem_q;
      negq_d   = negq_q;
      negr_d   = negr_q;
      dz_d     = dz_q;
      ovf_d    = ovf_q;
      case (state_q)
         IDLE: begin
            // done_q marks the retire cycle, which still counts as busy
            if (bus.start && !done_q) begin
               is_rem_d = bus.op[1];
               negq_d   = a_neg ^ b_neg;
               negr_d   = a_neg;
               dz_d     = in_dz;
               ovf_d    = in_ovf;
               rs1_d    = bus.rs1;
               quo_d    = a_abs;
               rem_d    = 32'd0;
               dvs_d    = b_abs;
               cnt_d    = 5'd0;
`ifdef DIV_FAST_SPECIAL_EN
               state_d  = (in_dz | in_ovf) ? FIX : CALC;
`else
               state_d  = CALC;
`endif
            end
         end
         CALC: begin
            if (!trial[32]) begin
               rem_d = trial[31:0];
               quo_d = {quo_q[30:0], 1'b1};
            end else begin
               rem_d = shifted[31:0];
               quo_d = {quo_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = FIX;
            end
         end
         FIX: begin
            if (dz_q) begin
               res_d = is_rem_q ? rs1_q : 32'hFFFF_FFFF;
            end else if (ovf_q) begin
               res_d = is_rem_q ? 32'd0 : 32'h8000_0000;
            end else begin
               res_d = is_rem_q ? r_fix : q_fix;
            end
            state_d = DONE;
         end
         DONE: begin
            rd_d    = res_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= 5'd0;
         quo_q    <= 32'd0;
         rem_q    <= 32'd0;
         dvs_q    <= 32'd0;
         rs1_q    <= 32'd0;
         res_q    <= 32'd0;
         rd_q     <= 32'd0;
         done_q   <= 1'b0;
         is_rem_q <= 1'b0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         dz_q     <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         quo_q    <= quo_d;
         rem_q    <= rem_d;
         dvs_q    <= dvs_d;
         rs1_q    <= rs1_d;
         res_q    <= res_d;
         rd_q     <= rd_d;
         done_q   <= done_d;
         is_rem_q <= is_rem_d;
         negq_q   <= negq_d;
         negr_q   <= negr_d;
         dz_q     <= dz_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.busy = (state_q != IDLE) | done_q;
   assign bus.done = done_q;
   assign bus.rd   = rd_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - Self-checking bench for div_unit against an arithmetic reference model.
module tb_div_unit;

   logic clk = 1'b0;
   logic rst;
   div_unit_if bus ();

   div_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

`ifdef DIV_FAST_SPECIAL_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct packed {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      int sa;
      int sb;
      sa = int'(a);
      sb = int'(b);
      if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
      if (o[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return o[1] ? 32'd0 : 32'h8000_0000;
      case (o)
         2'd0:    return 32'(sa / sb);
         2'd1:    return a / b;
         2'd2:    return 32'(sa % sb);
         default: return a % b;
      endcase
   endfunction

   function automatic int exp_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      bit special;
      special = (b == 32'd0) || (o[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      return (FAST && special) ? 2 : 34;
   endfunction

   // Issue one op; lat counts rising edges after the accept edge until done is seen.
   task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit noisy,
                        output int lat, output logic [31:0] res, output logic busy_after);
      bus.start = 1'b1;
      bus.op    = o;
      bus.rs1   = a;
      bus.rs2   = b;
      @(negedge clk);
      lat = 0;
      bus.start = 1'b0;
      while (bus.done !== 1'b1 && lat < 100) begin
         if (noisy) begin
            bus.start = 1'($urandom);
            bus.op    = 2'($urandom);
            bus.rs1   = $urandom;
            bus.rs2   = $urandom;
         end
         @(negedge clk);
         lat++;
      end
      res = bus.rd;
      if (noisy) begin
         bus.start = 1'b1;
         bus.rs1   = $urandom;
      end
      @(negedge clk);
      bus.start  = 1'b0;
      busy_after = bus.busy;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.op = 2'd0;
      bus.rs1 = 32'd0;
      bus.rs2 = 32'd0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      n_cmp++;
      if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
      n_cmp++;
      if (bus.rd !== 32'd0) begin n_fail++; $display("FAIL reset_rd: got %h expected 0", bus.rd); end
      rst = 1'b0;
   endtask

   task automatic test_directed;
      vec_t v[$];
      int lat;
      logic [31:0] res;
      logic ba;
      v.push_back('{2'd1, 32'd100, 32'd7, 32'h0000_000E});
      v.push_back('{2'd3, 32'd100, 32'd7, 32'h0000_0002});
      v.push_back('{2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD});
      v.push_back('{2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF});
      v.push_back('{2'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003});
      v.push_back('{2'd1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF});
      v.push_back('{2'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB});
      v.push_back('{2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
      v.push_back('{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000});
      v.push_back('{2'd0, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF});
      foreach (v[i]) begin
         do_op(v[i].op, v[i].a, v[i].b, 1'b0, lat, res, ba);
         n_cmp++;
         if (res !== v[i].exp) begin
            n_fail++;
            $display("FAIL directed_rd[%0d]: op=%0d a=%h b=%h got %h expected %h", i, v[i].op, v[i].a, v[i].b, res, v[i].exp);
         end
         n_cmp++;
         if (lat != exp_lat(v[i].op, v[i].a, v[i].b)) begin
            n_fail++;
            $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, exp_lat(v[i].op, v[i].a, v[i].b));
         end
         n_cmp++;
         if (bus.rd !== v[i].exp) begin
            n_fail++;
            $display("FAIL directed_rd_hold[%0d]: got %h expected %h", i, bus.rd, v[i].exp);
         end
      end
   endtask

   task automatic test_random;
      int lat;
      int kind;
      logic [1:0] o;
      logic [31:0] a, b, exp, res;
      logic ba;
      for (int i = 0; i < 30; i++) begin
         kind = $urandom_range(0, 5);
         o = 2'($urandom);
         a = $urandom;
         b = $urandom;
         case (kind)
            0: b = 32'd0;
            1: begin
               o = ($urandom_range(0, 1) != 0) ? 2'd2 : 2'd0;
               a = 32'h8000_0000;
               b = 32'hFFFF_FFFF;
            end
            2: begin
               a = 32'($signed(8'($urandom)));
               b = 32'($signed(4'($urandom)));
            end
            default: ;
         endcase
         exp = ref_model(o, a, b);
         do_op(o, a, b, 1'b1, lat, res, ba);
         n_cmp++;
         if (res !== exp) begin
            n_fail++;
            $display("FAIL random_rd[%0d]: op=%0d a=%h b=%h got %h expected %h", i, o, a, b, res, exp);
         end
         n_cmp++;
         if (lat != exp_lat(o, a, b)) begin
            n_fail++;
            $display("FAIL random_latency[%0d]: got %0d expected %0d", i, lat, exp_lat(o, a, b));
         end
         n_cmp++;
         if (ba !== 1'b0) begin
            n_fail++;
            $display("FAIL random_done_cycle_start[%0d]: busy got %b expected 0", i, ba);
         end
      end
   endtask

   task automatic test_busy_ignore;
      int k;
      int lat;
      bit seen;
      logic [31:0] res;
      logic ba;
      bus.start = 1'b1;
      bus.op = 2'd1;
      bus.rs1 = 32'd100;
      bus.rs2 = 32'd7;
      @(negedge clk);
      bus.start = 1'b0;
      k = 0;
      while (bus.done !== 1'b1 && k < 100) begin
         if (k == 5) begin
            bus.start = 1'b1;
            bus.rs1 = 32'd50;
            bus.rs2 = 32'd5;
         end else begin
            bus.start = 1'b0;
         end
         @(negedge clk);
         k++;
      end
      n_cmp++;
      if (k != 34) begin n_fail++; $display("FAIL busy_ignore_latency: got %0d expected 34", k); end
      n_cmp++;
      if (bus.rd !== 32'd14) begin n_fail++; $display("FAIL busy_ignore_rd: got %h expected 0000000e", bus.rd); end
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      n_cmp++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL done_cycle_start_busy: got %b expected 0", bus.busy); end
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done === 1'b1) seen = 1'b1;
      end
      n_cmp++;
      if (seen) begin n_fail++; $display("FAIL busy_ignore_extra_done: got 1 expected 0"); end
      do_op(2'd1, 32'd50, 32'd5, 1'b0, lat, res, ba);
      n_cmp++;
      if (res !== 32'd10) begin n_fail++; $display("FAIL after_done_rd: got %h expected 0000000a", res); end
      n_cmp++;
      if (lat != 34) begin n_fail++; $display("FAIL after_done_latency: got %0d expected 34", lat); end
   endtask

   task automatic test_reset_abort;
      int lat;
      logic [31:0] res;
      logic ba;
      bus.start = 1'b1;
      bus.op = 2'd1;
      bus.rs1 = 32'd100;
      bus.rs2 = 32'd7;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
      n_cmp++;
      if (bus.done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b expected 0", bus.done); end
      n_cmp++;
      if (bus.rd !== 32'd0) begin n_fail++; $display("FAIL abort_rd: got %h expected 0", bus.rd); end
      rst = 1'b0;
      do_op(2'd1, 32'd9, 32'd3, 1'b0, lat, res, ba);
      n_cmp++;
      if (res !== 32'd3) begin n_fail++; $display("FAIL abort_next_rd: got %h expected 00000003", res); end
      n_cmp++;
      if (lat != 34) begin n_fail++; $display("FAIL abort_next_latency: got %0d expected 34", lat); end
   endtask

   task automatic test_back_to_back;
      int lat;
      logic [1:0] o;
      logic [31:0] a, b, exp, res;
      logic ba;
      for (int i = 0; i < 4; i++) begin
         o = 2'(i);
         a = $urandom;
         b = $urandom_range(1, 1000);
         exp = ref_model(o, a, b);
         do_op(o, a, b, 1'b0, lat, res, ba);
         n_cmp++;
         if (res !== exp) begin
            n_fail++;
            $display("FAIL b2b_rd[%0d]: op=%0d a=%h b=%h got %h expected %h", i, o, a, b, res, exp);
         end
         n_cmp++;
         if (lat != 34) begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d expected 34", i, lat); end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_busy_ignore();
      test_reset_abort();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
